// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the L1 I-cache, L1 D-cache, the cache/memory arbiter and the memory port.
// slave: arbiter side; master: cache/memory environment side.
interface cache_mem_arbiter_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CLSIZE = 256
) ();
  logic              i_strobe_i;
  logic [XLEN-1:0]   i_addr_i;
  logic              i_ready_o;
  logic [CLSIZE-1:0] i_data_o;
  logic              d_strobe_i;
  logic [XLEN-1:0]   d_addr_i;
  logic              d_rw_i;
  logic [CLSIZE-1:0] d_data_i;
  logic              d_ready_o;
  logic [CLSIZE-1:0] d_data_o;
  logic              m_strobe_o;
  logic [XLEN-1:0]   m_addr_o;
  logic              m_rw_o;
  logic [CLSIZE-1:0] m_data_o;
  logic              m_ready_i;
  logic [CLSIZE-1:0] m_data_i;

  modport slave (
    input  i_strobe_i, i_addr_i, d_strobe_i, d_addr_i, d_rw_i, d_data_i, m_ready_i, m_data_i,
    output i_ready_o, i_data_o, d_ready_o, d_data_o, m_strobe_o, m_addr_o, m_rw_o, m_data_o
  );

  modport master (
    output i_strobe_i, i_addr_i, d_strobe_i, d_addr_i, d_rw_i, d_data_i, m_ready_i, m_data_i,
    input  i_ready_o, i_data_o, d_ready_o, d_data_o, m_strobe_o, m_addr_o, m_rw_o, m_data_o
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Serializes full-line I-cache refills and D-cache refills/write-backs onto one memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise the D-cache wins ties.
module cache_mem_arbiter #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CLSIZE = 256
) (
  input logic                clk_i,
  input logic                rst_i,
  cache_mem_arbiter_if.slave bus
);
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StGrantI = 2'd1;
  localparam logic [1:0] StGrantD = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic GrantI = 1'b0;
  localparam logic GrantD = 1'b1;

  logic [1:0]        r_state, w_state_next;
  logic              r_last_grant, w_last_grant_next;
  logic              r_m_strobe, w_m_strobe_next;
  logic [XLEN-1:0]   r_m_addr, w_m_addr_next;
  logic              r_m_rw, w_m_rw_next;
  logic [CLSIZE-1:0] r_m_data, w_m_data_next;

  logic w_tie_to_d;
  logic w_grant_d;
  logic w_grant_i;

`ifdef ARB_ROUND_ROBIN_EN
  assign w_tie_to_d = (r_last_grant == GrantI);
`else
  assign w_tie_to_d = 1'b1;
  logic w_unused_last_grant;
  assign w_unused_last_grant = r_last_grant;
`endif

  assign w_grant_d = (r_state == StIdle) && bus.d_strobe_i && (!bus.i_strobe_i || w_tie_to_d);
  assign w_grant_i = (r_state == StIdle) && bus.i_strobe_i && !w_grant_d;

  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    w_m_strobe_next   = r_m_strobe;
    w_m_addr_next     = r_m_addr;
    w_m_rw_next       = r_m_rw;
    w_m_data_next     = r_m_data;
    case (r_state)
      StIdle: begin
        if (w_grant_d) begin
          w_state_next    = StGrantD;
          w_m_strobe_next = 1'b1;
          w_m_addr_next   = bus.d_addr_i;
          w_m_rw_next     = bus.d_rw_i;
          w_m_data_next   = bus.d_data_i;
        end else if (w_grant_i) begin
          w_state_next    = StGrantI;
          w_m_strobe_next = 1'b1;
          w_m_addr_next   = bus.i_addr_i;
          w_m_rw_next     = 1'b0;
          w_m_data_next   = '0;
        end
      end
      StGrantI, StGrantD: begin
        if (bus.m_ready_i) begin
          w_state_next      = StDone;
          w_last_grant_next = (r_state == StGrantD) ? GrantD : GrantI;
          w_m_strobe_next   = 1'b0;
          w_m_addr_next     = '0;
          w_m_rw_next       = 1'b0;
          w_m_data_next     = '0;
        end
      end
      // One dead cycle lets the owner's registered strobe fall before re-arbitration.
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_last_grant <= GrantI;
      r_m_strobe   <= 1'b0;
      r_m_addr     <= '0;
      r_m_rw       <= 1'b0;
      r_m_data     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
      r_m_strobe   <= w_m_strobe_next;
      r_m_addr     <= w_m_addr_next;
      r_m_rw       <= w_m_rw_next;
      r_m_data     <= w_m_data_next;
    end
  end

  // Ready is gated by reset so an aborted transaction never reports completion.
  assign bus.i_ready_o  = bus.m_ready_i && (r_state == StGrantI) && !rst_i;
  assign bus.d_ready_o  = bus.m_ready_i && (r_state == StGrantD) && !rst_i;
  assign bus.i_data_o   = bus.m_data_i;
  assign bus.d_data_o   = bus.m_data_i;
  assign bus.m_strobe_o = r_m_strobe;
  assign bus.m_addr_o   = r_m_addr;
  assign bus.m_rw_o     = r_m_rw;
  assign bus.m_data_o   = r_m_data;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed vector table, arbitration/reset sequences
// and randomized traffic against a transaction-level reference model.
module tb_cache_mem_arbiter;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CLSIZE = 256;
  localparam logic [XLEN-1:0]   IAddr = 32'h0000_1020;
  localparam logic [XLEN-1:0]   DAddr = 32'h8000_0040;
  localparam logic [CLSIZE-1:0] PatA  = {8{32'hA5A5_0F0F}};
  localparam logic [CLSIZE-1:0] PatB  = {8{32'h1234_5678}};
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RrBuild = 1'b1;
`else
  localparam bit RrBuild = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.XLEN(XLEN), .CLSIZE(CLSIZE)) bus ();

  cache_mem_arbiter #(.XLEN(XLEN), .CLSIZE(CLSIZE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Observed outputs of the most recent cycle.
  logic              obs_ms, obs_ir, obs_dr, obs_rw;
  logic [XLEN-1:0]   obs_addr;
  logic [CLSIZE-1:0] obs_mdata;

  // Reference model: current memory transaction (owner 0 none, 1 I, 2 D) and rest cycles.
  typedef struct {
    int                owner;
    logic [XLEN-1:0]   addr;
    logic              rw;
    logic [CLSIZE-1:0] data;
  } txn_t;
  txn_t md_tx;
  int   md_cool;
  int   md_last;

  task automatic chkw(input string name, input logic [CLSIZE-1:0] act,
                      input logic [CLSIZE-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [CLSIZE-1:0] rand_line();
    logic [CLSIZE-1:0] v;
    for (int w = 0; w < CLSIZE / 32; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic model_init();
    md_tx.owner = 0;
    md_tx.addr  = '0;
    md_tx.rw    = 1'b0;
    md_tx.data  = '0;
    md_cool     = 0;
    md_last     = 1;
  endtask

  task automatic model_check();
    logic busy;
    busy = (md_tx.owner != 0);
    chk1("m_strobe", obs_ms, busy);
    chkw("m_addr", CLSIZE'(obs_addr), busy ? CLSIZE'(md_tx.addr) : '0);
    chk1("m_rw", obs_rw, busy ? md_tx.rw : 1'b0);
    chkw("m_data", obs_mdata, busy ? md_tx.data : '0);
    chk1("i_ready", obs_ir, !rst && bus.m_ready_i && (md_tx.owner == 1));
    chk1("d_ready", obs_dr, !rst && bus.m_ready_i && (md_tx.owner == 2));
    chkw("i_data", bus.i_data_o, bus.m_data_i);
    chkw("d_data", bus.d_data_o, bus.m_data_i);
  endtask

  task automatic model_step();
    int pick;
    pick = 0;
    if (rst) begin
      model_init();
    end else if (md_tx.owner != 0) begin
      if (bus.m_ready_i) begin
        md_last     = md_tx.owner;
        md_tx.owner = 0;
        md_cool     = 1;
      end
    end else if (md_cool > 0) begin
      md_cool--;
    end else begin
      if (bus.i_strobe_i && bus.d_strobe_i) pick = RrBuild ? ((md_last == 1) ? 2 : 1) : 2;
      else if (bus.d_strobe_i) pick = 2;
      else if (bus.i_strobe_i) pick = 1;
      if (pick == 1) begin
        md_tx = '{owner: 1, addr: bus.i_addr_i, rw: 1'b0, data: '0};
      end else if (pick == 2) begin
        md_tx = '{owner: 2, addr: bus.d_addr_i, rw: bus.d_rw_i, data: bus.d_data_i};
      end
    end
  endtask

  // Inputs are set just after a rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    #1;
    obs_ms    = bus.m_strobe_o;
    obs_ir    = bus.i_ready_o;
    obs_dr    = bus.d_ready_o;
    obs_rw    = bus.m_rw_o;
    obs_addr  = bus.m_addr_o;
    obs_mdata = bus.m_data_o;
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic       rst, is, ds, drw, mr;
    logic       ms, mrw, ir, dr;
    logic [1:0] sel;  // expected m_addr/m_data: 0 zero, 1 I request, 2 D request
  } vec_t;

  function automatic vec_t mk(input int r, input int is, input int ds, input int drw, input int mr,
                              input int ms, input int mrw, input int ir, input int dr, input int sel);
    vec_t v;
    v.rst = (r != 0);   v.is = (is != 0);   v.ds = (ds != 0); v.drw = (drw != 0);
    v.mr  = (mr != 0);  v.ms = (ms != 0);   v.mrw = (mrw != 0);
    v.ir  = (ir != 0);  v.dr = (dr != 0);   v.sel = 2'(sel);
    return v;
  endfunction

  vec_t vecs [19];
  int   exp_order [6];
  int   order [$];
  int   gaps [$];

  initial begin
    int   i_left, d_left, idle_run;
    logic i_seen, d_seen, prev_ms, prev_rdy, started, got;
    logic [XLEN-1:0] first_addr;

    rst = 1'b1;
    bus.i_strobe_i = 1'b0; bus.i_addr_i = '0;
    bus.d_strobe_i = 1'b0; bus.d_addr_i = '0; bus.d_rw_i = 1'b0; bus.d_data_i = '0;
    bus.m_ready_i  = 1'b0; bus.m_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    model_init();

    //            rst is ds drw mr | ms rw ir dr sel
    vecs[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 0,  1, 0, 0, 0, 1);
    vecs[4]  = mk(0, 1, 0, 0, 0,  1, 0, 0, 0, 1);
    vecs[5]  = mk(0, 1, 0, 0, 0,  1, 0, 0, 0, 1);
    vecs[6]  = mk(0, 1, 0, 0, 1,  1, 0, 1, 0, 1);
    vecs[7]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 1, 1, 0,  0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 1, 1, 0,  1, 1, 0, 0, 2);
    vecs[12] = mk(0, 0, 1, 1, 0,  1, 1, 0, 0, 2);
    vecs[13] = mk(0, 0, 1, 1, 1,  1, 1, 0, 1, 2);
    vecs[14] = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[16] = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[17] = mk(0, 1, 0, 0, 1,  1, 0, 1, 0, 1);
    vecs[18] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);

    bus.i_addr_i = IAddr; bus.d_addr_i = DAddr; bus.d_data_i = PatB; bus.m_data_i = PatA;
    for (int r = 0; r < 19; r++) begin
      rst            = vecs[r].rst;
      bus.i_strobe_i = vecs[r].is;
      bus.d_strobe_i = vecs[r].ds;
      bus.d_rw_i     = vecs[r].drw;
      bus.m_ready_i  = vecs[r].mr;
      tick();
      chk1($sformatf("row%0d m_strobe", r), obs_ms, vecs[r].ms);
      chk1($sformatf("row%0d m_rw", r), obs_rw, vecs[r].mrw);
      chk1($sformatf("row%0d i_ready", r), obs_ir, vecs[r].ir);
      chk1($sformatf("row%0d d_ready", r), obs_dr, vecs[r].dr);
      chkw($sformatf("row%0d m_addr", r), CLSIZE'(obs_addr),
           (vecs[r].sel == 2'd1) ? CLSIZE'(IAddr) : (vecs[r].sel == 2'd2) ? CLSIZE'(DAddr) : '0);
      chkw($sformatf("row%0d m_data", r), obs_mdata, (vecs[r].sel == 2'd2) ? PatB : '0);
    end

    // Both caches request three lines each, re-raising strobes right after their DONE cycle.
    rst = 1'b1; bus.i_strobe_i = 1'b0; bus.d_strobe_i = 1'b0; bus.m_ready_i = 1'b0;
    tick();
    rst = 1'b0; bus.d_rw_i = 1'b0;
    i_left = 3; d_left = 3; i_seen = 0; d_seen = 0; prev_ms = 0; prev_rdy = 0;
    idle_run = 0; started = 0;
    for (int c = 0; c < 200 && (i_left > 0 || d_left > 0); c++) begin
      bus.i_strobe_i = !i_seen && (i_left > 0);
      bus.d_strobe_i = !d_seen && (d_left > 0);
      bus.m_ready_i  = prev_ms && !prev_rdy;
      tick();
      if (obs_ms && !prev_ms && started) gaps.push_back(idle_run);
      if (obs_ms) begin started = 1; idle_run = 0; end
      else idle_run++;
      if (obs_ir) begin order.push_back(1); i_left--; end
      if (obs_dr) begin order.push_back(2); d_left--; end
      i_seen = obs_ir; d_seen = obs_dr;
      prev_ms = obs_ms; prev_rdy = bus.m_ready_i;
    end
    if (RrBuild) exp_order = '{2, 1, 2, 1, 2, 1};
    else         exp_order = '{2, 2, 2, 1, 1, 1};
    chki("arb completions", order.size(), 6);
    for (int k = 0; k < 6; k++)
      chki($sformatf("arb grant%0d owner", k), (k < order.size()) ? order[k] : 0, exp_order[k]);
    chki("arb gap count", gaps.size(), 5);
    for (int k = 0; k < gaps.size(); k++) chki($sformatf("arb gap%0d", k), gaps[k], 2);
    bus.i_strobe_i = 1'b0; bus.d_strobe_i = 1'b0; bus.m_ready_i = 1'b0;
    tick();

    // Reset while the D-cache owns the port, with memory answering in the same cycle.
    bus.d_strobe_i = 1'b1; bus.d_rw_i = 1'b1; bus.d_addr_i = DAddr; bus.d_data_i = PatB;
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin tick(); got = obs_ms; end
    chk1("rst granted D", got, 1'b1);
    rst = 1'b1; bus.m_ready_i = 1'b1;
    tick();
    chk1("rst no d_ready", obs_dr, 1'b0);
    rst = 1'b0; bus.m_ready_i = 1'b0; bus.d_strobe_i = 1'b0; bus.d_rw_i = 1'b0;
    tick();
    chk1("rst m_strobe dropped", obs_ms, 1'b0);
    bus.i_strobe_i = 1'b1; bus.i_addr_i = IAddr;
    got = 0; first_addr = '0; prev_ms = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      bus.m_ready_i = prev_ms;
      tick();
      if (obs_ms && !prev_ms) first_addr = obs_addr;
      prev_ms = obs_ms;
      got = obs_ir;
    end
    chk1("post-rst I ready", got, 1'b1);
    chkw("post-rst I addr", CLSIZE'(first_addr), CLSIZE'(IAddr));
    bus.i_strobe_i = 1'b0; bus.m_ready_i = 1'b0;
    tick();

    // Random traffic, including spurious readies, latched-field churn and occasional resets.
    i_seen = 0; d_seen = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(199) == 0);
      if (rst || i_seen) bus.i_strobe_i = 1'b0;
      else if (!bus.i_strobe_i) bus.i_strobe_i = ($urandom_range(2) == 0);
      else if ($urandom_range(63) == 0) bus.i_strobe_i = 1'b0;
      if (rst || d_seen) bus.d_strobe_i = 1'b0;
      else if (!bus.d_strobe_i) bus.d_strobe_i = ($urandom_range(2) == 0);
      else if ($urandom_range(63) == 0) bus.d_strobe_i = 1'b0;
      bus.i_addr_i  = $urandom();
      bus.d_addr_i  = $urandom();
      bus.d_rw_i    = ($urandom_range(1) == 1);
      bus.d_data_i  = rand_line();
      bus.m_data_i  = rand_line();
      bus.m_ready_i = ($urandom_range(3) == 0);
      tick();
      i_seen = obs_ir; d_seen = obs_dr;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
